positron_layer_tx: RTL and testbench

Transmitter side of the positron stream handshake. Collects the one-posit-per-window results of `NB_POSITRONS` parallel positrons in a layer and re-emits them as a single framed serial stream (`sow_o` on the first word, `eow_o` on the last). That stream feeds the slave side of the next layer's positrons. Two ping-pong banks let one layer window be captured while the previous one is being transmitted.

---
 rtl/positron_layer_tx.sv | 122 ++++++++++++
 tb/tb_positron_layer_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/positron_layer_tx.sv
// Layer transmitter: captures one posit from every positron per window into a
// ping-pong bank pair and replays each window as a framed serial stream.
module positron_layer_tx #(
    parameter int POSIT_WIDTH  = 4,
    parameter int NB_POSITRONS = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NB_POSITRONS-1:0]              rts_i,
    input  logic [NB_POSITRONS-1:0]              eow_i,
    input  logic [NB_POSITRONS*POSIT_WIDTH-1:0]  posit_i,
    output logic                                 rtr_o,
    input  logic                                 rtr_i,
    output logic                                 rts_o,
    output logic                                 sow_o,
    output logic                                 eow_o,
    output logic [POSIT_WIDTH-1:0]               posit_o,
    output logic                                 err_o
);

    localparam int                IDX_W    = $clog2(NB_POSITRONS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NB_POSITRONS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_t;

    logic [POSIT_WIDTH-1:0] bank [2][NB_POSITRONS];
    logic [1:0]             full;
    logic [1:0]             full_next;
    logic                   wr_bank;
    logic                   rd_bank;
    logic                   rd_bank_next;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_next;
    tx_state_t              state;
    tx_state_t              state_next;
    logic                   cap;
    logic                   proto_err;

    // Upstream may only hand over a window when the write bank is free.
    assign rtr_o     = ~rst & ~full[wr_bank];
    assign cap       = rtr_o & (&rts_i) & (&eow_i);
    assign proto_err = rtr_o & (|rts_i) & ~(&(rts_i & eow_i));

    // NOTE: bank storage is deliberately left out of reset; the full flags
    // alone decide whether a bank holds a valid window.
    always_ff @(posedge clk) begin
        if (cap) begin
            for (int k = 0; k < NB_POSITRONS; k++) begin
                bank[wr_bank][k] <= posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            idx     <= '0;
            err_o   <= 1'b0;
        end else begin
            state   <= state_next;
            full    <= full_next;
            rd_bank <= rd_bank_next;
            idx     <= idx_next;
            if (cap) begin
                wr_bank <= ~wr_bank;
            end
            if (proto_err) begin
                err_o <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        rd_bank_next = rd_bank;
        full_next    = full;
        rts_o        = 1'b0;
        sow_o        = 1'b0;
        eow_o        = 1'b0;
        posit_o      = '0;

        if (cap) begin
            full_next[wr_bank] = 1'b1;
        end

        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                rts_o   = 1'b1;
                posit_o = bank[rd_bank][idx];
                sow_o   = (idx == '0);
                eow_o   = (idx == LAST_IDX);
                if (rtr_i) begin
                    if (idx == LAST_IDX) begin
                        idx_next           = '0;
                        full_next[rd_bank] = 1'b0;
                        rd_bank_next       = ~rd_bank;
                        // While sending, a capture can only target the other bank.
                        state_next = (full[~rd_bank] | cap) ? SEND : IDLE;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_positron_layer_tx.sv
// Directed bench for positron_layer_tx (4 positrons x 4-bit posits) with a
// scoreboard of expected serial words checked on every accepted handshake.
module tb_positron_layer_tx;

    localparam int PW = 4;
    localparam int NB = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NB-1:0]    rts_i;
    logic [NB-1:0]    eow_i;
    logic [NB*PW-1:0] posit_i;
    logic             rtr_o;
    logic             rtr_i;
    logic             rts_o;
    logic             sow_o;
    logic             eow_o;
    logic [PW-1:0]    posit_o;
    logic             err_o;

    typedef struct packed {
        logic          sow;
        logic          eow;
        logic [PW-1:0] posit;
    } word_t;

    word_t sb[$];
    word_t exp_w;
    int    total = 0;
    int    bad   = 0;

    positron_layer_tx #(
        .POSIT_WIDTH  (PW),
        .NB_POSITRONS (NB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rts_i   (rts_i),
        .eow_i   (eow_i),
        .posit_i (posit_i),
        .rtr_o   (rtr_o),
        .rtr_i   (rtr_i),
        .rts_o   (rts_o),
        .sow_o   (sow_o),
        .eow_o   (eow_o),
        .posit_o (posit_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic s, input logic e, input logic [PW-1:0] p);
        check(tag, 32'({rts_o, sow_o, eow_o, posit_o}), 32'({1'b1, s, e, p}));
    endtask

    task automatic push_window(input logic [NB*PW-1:0] data);
        for (int k = 0; k < NB; k++) begin
            sb.push_back('{sow: (k == 0), eow: (k == NB-1), posit: data[k*PW +: PW]});
        end
    endtask

    task automatic offer(input logic [NB*PW-1:0] data);
        rts_i   = '1;
        eow_i   = '1;
        posit_i = data;
    endtask

    task automatic idle_in();
        rts_i = '0;
        eow_i = '0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((sb.size() != 0 || rts_o) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'(0));
        check({tag, "_idle"}, 32'(rts_o), 32'(0));
    endtask

    // Scoreboard: every word accepted downstream must be the next expected one.
    always @(negedge clk) begin
        if (rst === 1'b0 && rts_o === 1'b1 && rtr_i === 1'b1) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("sb_word", 32'({sow_o, eow_o, posit_o}), 32'(exp_w));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PW-1:0] pp_seq [11];
        pp_seq = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};

        // Reset held 3 cycles with random inputs
        rst     = 1'b1;
        rtr_i   = 1'b0;
        rts_i   = 4'($urandom);
        eow_i   = 4'($urandom);
        posit_i = 16'($urandom);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_outs", 32'({rtr_o, rts_o, sow_o, eow_o, posit_o, err_o}), 32'(0));
            rts_i   = 4'($urandom);
            eow_i   = 4'($urandom);
            posit_i = 16'($urandom);
            rtr_i   = 1'($urandom);
        end
        rst   = 1'b0;
        rtr_i = 1'b1;
        idle_in();
        #1;
        check("rel_rtr", 32'(rtr_o), 32'(1));
        check("rel_rts", 32'(rts_o), 32'(0));

        // Single window
        offer(16'h4321);
        push_window(16'h4321);
        tick();
        idle_in();
        check("sw_lat_rts", 32'(rts_o), 32'(0));
        check("sw_lat_rtr", 32'(rtr_o), 32'(1));
        for (int k = 0; k < NB; k++) begin
            tick();
            check_word("sw_word", (k == 0), (k == NB-1), 4'(k + 1));
        end
        tick();
        check("sw_done", 32'(rts_o), 32'(0));

        // Downstream stall on word 2
        offer(16'h4321);
        push_window(16'h4321);
        tick();
        idle_in();
        tick();
        check_word("st_w1", 1'b1, 1'b0, 4'h1);
        tick();
        check_word("st_w2", 1'b0, 1'b0, 4'h2);
        rtr_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_word("st_hold", 1'b0, 1'b0, 4'h2);
        end
        rtr_i = 1'b1;
        tick();
        check_word("st_w3", 1'b0, 1'b0, 4'h3);
        tick();
        check_word("st_w4", 1'b0, 1'b1, 4'h4);
        tick();
        check("st_done", 32'(rts_o), 32'(0));

        // Ping-pong: two windows fill both banks, third waits for a free bank
        rtr_i = 1'b0;
        offer(16'h4321);
        push_window(16'h4321);
        tick();
        check("pp_rtr_after_a", 32'(rtr_o), 32'(1));
        offer(16'h8765);
        push_window(16'h8765);
        tick();
        check("pp_rtr_both_full", 32'(rtr_o), 32'(0));
        offer(16'hCBA9);
        tick();
        check("pp_rtr_stalled", 32'(rtr_o), 32'(0));
        check_word("pp_w1_held", 1'b1, 1'b0, 4'h1);
        rtr_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            check_word("pp_word", (i == 3 || i == 7), (i == 2 || i == 6 || i == 10), pp_seq[i]);
            if (i == 3) begin
                check("pp_rtr_freed", 32'(rtr_o), 32'(1));
                push_window(16'hCBA9);
            end
            if (i == 4) begin
                check("pp_rtr_c_taken", 32'(rtr_o), 32'(0));
                idle_in();
            end
        end
        tick();
        check("pp_done", 32'(rts_o), 32'(0));

        // Partial request: protocol error, nothing captured
        check("pe_rtr", 32'(rtr_o), 32'(1));
        rts_i = 4'b0111;
        eow_i = 4'b0111;
        tick();
        idle_in();
        check("pe_err", 32'(err_o), 32'(1));
        for (int c = 0; c < 3; c++) begin
            tick();
            check("pe_no_cap_sticky", 32'({rts_o, err_o}), 32'(2'b01));
        end

        // Reset in the middle of a window
        offer(16'hFEDC);
        push_window(16'hFEDC);
        tick();
        idle_in();
        tick();
        check_word("rm_w1", 1'b1, 1'b0, 4'hC);
        tick();
        check_word("rm_w2", 1'b0, 1'b0, 4'hD);
        rst = 1'b1;
        tick();
        check("rm_outs", 32'({rtr_o, rts_o, sow_o, eow_o, posit_o, err_o}), 32'(0));
        sb.delete();
        rst = 1'b0;
        #1;
        check("rm_rel_rtr", 32'(rtr_o), 32'(1));
        for (int c = 0; c < 6; c++) begin
            tick();
            check("rm_no_tail", 32'({rts_o, eow_o}), 32'(0));
        end
        offer(16'h5A3C);
        push_window(16'h5A3C);
        tick();
        idle_in();
        tick();
        check_word("rm_new_w1", 1'b1, 1'b0, 4'hC);
        drain("rm_new", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
